// File: rtl/ordenador_pkg.sv
// Shared definitions for the sequential bubble sorter: FSM encoding and the
// width helpers used for the swap counter and the index/pass counters.
package ordenador_pkg;

  typedef enum logic [1:0] {
    CARGA  = 2'd0,
    ORDENA = 2'd1,
    ENVIA  = 2'd2
  } estado_t;

  // Index counters address 0..n-1; at least one bit even for tiny n.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int trocas_w(input int n);
    return $clog2((n * (n - 1)) / 2 + 1);
  endfunction

endpackage

// File: rtl/comparador4bit_behav.sv
// Behavioural 4-bit unsigned magnitude comparator; exactly one of
// maior/menor/igual is high for any pair of operands.
module comparador4bit_behav (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       maior,
  output logic       menor,
  output logic       igual
);

  // Magnitude decode of the two operands.
  always_comb begin
    maior = 1'b0;
    menor = 1'b0;
    igual = 1'b0;
    if (a > b) begin
      maior = 1'b1;
    end else if (a < b) begin
      menor = 1'b1;
    end else begin
      igual = 1'b1;
    end
  end

endmodule

// File: rtl/ordenador_seq.sv
// Sequential bubble sorter: loads N 4-bit values, sorts them in place with one
// shared comparator over exactly N(N-1)/2 cycles, then streams them out.
module ordenador_seq
  import ordenador_pkg::*;
#(
  parameter int N           = 4,
  parameter bit DESCENDENTE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             in_dado,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             out_dado,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ocupado,
  output logic [trocas_w(N)-1:0] trocas
);

  localparam int IW = idx_w(N);
  localparam int TW = trocas_w(N);

  estado_t          state_r;
  estado_t          state_nxt_s;
  logic [3:0]       mem_r [N];
  logic [IW-1:0]    idx_r;
  logic [IW-1:0]    j_r;
  logic [IW-1:0]    lim_r;
  logic [IW-1:0]    k_r;
  logic [TW-1:0]    trocas_r;

  logic [IW-1:0]    j_nxt_s;
  logic [3:0]       a_s;
  logic [3:0]       b_s;
  logic             maior_s;
  logic             menor_s;
  logic             igual_s;
  logic             troca_s;
  logic             fim_passo_s;
  logic             in_hs_s;
  logic             out_hs_s;

  assign j_nxt_s     = j_r + IW'(1);
  assign a_s         = mem_r[j_r];
  assign b_s         = mem_r[j_nxt_s];
  // Equal operands never swap, which keeps the sort stable.
  assign troca_s     = DESCENDENTE ? menor_s : maior_s;
  assign fim_passo_s = (j_nxt_s == lim_r);
  assign in_hs_s     = in_valid && (state_r == CARGA);
  assign out_hs_s    = out_ready && (state_r == ENVIA);

  comparador4bit_behav u_cmp (
    .a     (a_s),
    .b     (b_s),
    .maior (maior_s),
    .menor (menor_s),
    .igual (igual_s)
  );

  assign in_ready  = (state_r == CARGA);
  assign out_valid = (state_r == ENVIA);
  assign ocupado   = (state_r == ORDENA) || (state_r == ENVIA);
  assign out_dado  = mem_r[k_r];
  assign trocas    = trocas_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CARGA;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CARGA: begin
        if (in_hs_s && (idx_r == IW'(N - 1))) begin
          state_nxt_s = ORDENA;
        end else begin
          state_nxt_s = CARGA;
        end
      end
      ORDENA: begin
        if (fim_passo_s && (lim_r == IW'(1))) begin
          state_nxt_s = ENVIA;
        end else begin
          state_nxt_s = ORDENA;
        end
      end
      ENVIA: begin
        if (out_hs_s && (k_r == IW'(N - 1))) begin
          state_nxt_s = CARGA;
        end else begin
          state_nxt_s = ENVIA;
        end
      end
      default: state_nxt_s = CARGA;
    endcase
  end

  // Element storage, counters and swap tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= 4'd0;
      end
      idx_r    <= '0;
      j_r      <= '0;
      lim_r    <= IW'(N - 1);
      k_r      <= '0;
      trocas_r <= '0;
    end else begin
      case (state_r)
        CARGA: begin
          if (in_hs_s) begin
            mem_r[idx_r] <= in_dado;
            if (idx_r == '0) begin
              trocas_r <= '0;
            end
            if (idx_r == IW'(N - 1)) begin
              idx_r <= '0;
              j_r   <= '0;
              lim_r <= IW'(N - 1);
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end
        end
        ORDENA: begin
          // Two write ports: both neighbours update on the same edge.
          if (troca_s) begin
            mem_r[j_r]     <= b_s;
            mem_r[j_nxt_s] <= a_s;
            trocas_r       <= trocas_r + TW'(1);
          end
          if (fim_passo_s) begin
            j_r   <= '0;
            lim_r <= lim_r - IW'(1);
          end else begin
            j_r <= j_nxt_s;
          end
        end
        ENVIA: begin
          if (out_hs_s) begin
            if (k_r == IW'(N - 1)) begin
              k_r <= '0;
            end else begin
              k_r <= k_r + IW'(1);
            end
          end
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ordenador_seq.sv
// Directed bench for ordenador_seq: an ascending and a descending instance
// share all inputs and are checked against hand-computed sort results.
module tb_ordenador_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_dado;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, ocupado_a;
  logic [3:0] out_dado_a;
  logic [2:0] trocas_a;
  logic       in_ready_d, out_valid_d, ocupado_d;
  logic [3:0] out_dado_d;
  logic [2:0] trocas_d;

  int total;
  int passed;
  int failed;

  ordenador_seq #(.N(4), .DESCENDENTE(1'b0)) dut_asc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dado   (in_dado),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .out_dado  (out_dado_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .ocupado   (ocupado_a),
    .trocas    (trocas_a)
  );

  ordenador_seq #(.N(4), .DESCENDENTE(1'b1)) dut_desc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dado   (in_dado),
    .in_valid  (in_valid),
    .in_ready  (in_ready_d),
    .out_dado  (out_dado_d),
    .out_valid (out_valid_d),
    .out_ready (out_ready),
    .ocupado   (ocupado_d),
    .trocas    (trocas_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First element in the most significant nibble.
  task automatic load(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_dado  = v[15 - 4*i -: 4];
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sort(input string tag);
    int n;
    n = 0;
    chk({tag, "_ocupado"}, {31'd0, ocupado_a}, 32'd1);
    chk({tag, "_in_ready_sort"}, {31'd0, in_ready_a}, 32'd0);
    while (out_valid_a !== 1'b1 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd6);
  endtask

  task automatic unload(input logic [15:0] ea, input logic [15:0] ed,
                        input int ta, input int td, input string tag);
    chk({tag, "_trocas_asc"}, {29'd0, trocas_a}, ta);
    chk({tag, "_trocas_desc"}, {29'd0, trocas_d}, td);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_out_valid"}, {31'd0, out_valid_a}, 32'd1);
      chk({tag, "_dado_asc"}, {28'd0, out_dado_a}, {28'd0, ea[15 - 4*i -: 4]});
      chk({tag, "_dado_desc"}, {28'd0, out_dado_d}, {28'd0, ed[15 - 4*i -: 4]});
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_recover_in_ready"}, {31'd0, in_ready_a}, 32'd1);
    chk({tag, "_recover_out_valid"}, {31'd0, out_valid_d}, 32'd0);
    chk({tag, "_recover_ocupado"}, {31'd0, ocupado_a}, 32'd0);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_dado   = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_out_dado", {28'd0, out_dado_a}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado_d}, 32'd0);
    chk("rst_trocas", {29'd0, trocas_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load({4'd10, 4'd5, 4'd2, 4'd15});
    wait_sort("mixed");
    unload({4'd2, 4'd5, 4'd10, 4'd15}, {4'd15, 4'd10, 4'd5, 4'd2}, 3, 3, "mixed");

    load({4'd0, 4'd3, 4'd5, 4'd15});
    wait_sort("sorted");
    unload({4'd0, 4'd3, 4'd5, 4'd15}, {4'd15, 4'd5, 4'd3, 4'd0}, 0, 6, "sorted");

    load({4'd15, 4'd12, 4'd3, 4'd0});
    wait_sort("reverse");
    unload({4'd0, 4'd3, 4'd12, 4'd15}, {4'd15, 4'd12, 4'd3, 4'd0}, 6, 0, "reverse");

    load({4'd10, 4'd10, 4'd2, 4'd10});
    wait_sort("dups");
    unload({4'd2, 4'd10, 4'd10, 4'd10}, {4'd10, 4'd10, 4'd10, 4'd2}, 2, 1, "dups");

    // Backpressure with input activity that must be ignored.
    load({4'd3, 4'd14, 4'd7, 4'd1});
    wait_sort("bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_dado  = 4'd7;
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_dado", {28'd0, out_dado_a}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready_a}, 32'd0);
      chk("bp_hold_out_valid", {31'd0, out_valid_a}, 32'd1);
      chk("bp_hold_trocas", {29'd0, trocas_a}, 32'd4);
    end
    in_valid = 1'b0;
    unload({4'd1, 4'd3, 4'd7, 4'd14}, {4'd14, 4'd7, 4'd3, 4'd1}, 4, 2, "bp");

    // Reset asserted during the third ORDENA cycle.
    load({4'd10, 4'd5, 4'd2, 4'd15});
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_trocas_before", {29'd0, trocas_a}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("mid_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("mid_out_dado", {28'd0, out_dado_a}, 32'd0);
    chk("mid_ocupado", {31'd0, ocupado_a}, 32'd0);
    chk("mid_trocas", {29'd0, trocas_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load({4'd9, 4'd1, 4'd4, 4'd1});
    wait_sort("after_rst");
    unload({4'd1, 4'd1, 4'd4, 4'd9}, {4'd9, 4'd4, 4'd1, 4'd1}, 4, 1, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
